// File: rtl/cart_bus_master_if.sv
// rtl/cart_bus_master_if.sv - host request and cartridge bus signal bundle
interface cart_bus_master_if;
  // host request side
  logic        REQ;
  logic [23:1] REQ_A;
  logic        REQ_WE;
  logic [1:0]  REQ_BE;
  logic [15:0] REQ_D;
  logic        ACK;
  logic [15:0] REQ_Q;
  logic        BUS_ERR;
  // cartridge side
  logic [23:1] VA;
  logic [15:0] VDO;
  logic [15:0] VDI;
  logic        AS_N;
  logic        LWR_N;
  logic        UWR_N;
  logic        CE0_N;
  logic        CAS0_N;
  logic        CAS2_N;
  logic        ASEL_N;
  logic        TIME_N;
  logic        DTACK_N;

  // the bus initiator
  modport master (
    input  REQ, REQ_A, REQ_WE, REQ_BE, REQ_D, VDI, DTACK_N,
    output ACK, REQ_Q, BUS_ERR, VA, VDO,
    output AS_N, LWR_N, UWR_N, CE0_N, CAS0_N, CAS2_N, ASEL_N, TIME_N
  );

  // host plus cartridge responder
  modport slave (
    output REQ, REQ_A, REQ_WE, REQ_BE, REQ_D, VDI, DTACK_N,
    input  ACK, REQ_Q, BUS_ERR, VA, VDO,
    input  AS_N, LWR_N, UWR_N, CE0_N, CAS0_N, CAS2_N, ASEL_N, TIME_N
  );
endinterface

// File: rtl/cart_bus_master.sv
// rtl/cart_bus_master.sv - REQ/ACK host request to Mega Drive cartridge bus cycle
module cart_bus_master #(
  parameter int WAIT_CYC = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic               CLK,
  input  logic               RST,
  cart_bus_master_if.master  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_STRB = 2'd2;
  localparam logic [1:0] S_RCVR = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYC - 1);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  be_q, be_d;
  logic        ext_q, ext_d;
  logic [23:1] va_q, va_d;
  logic [15:0] vdo_q, vdo_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        bus_err_q, bus_err_d;
  logic        as_n_q, as_n_d;
  logic        lwr_n_q, lwr_n_d;
  logic        uwr_n_q, uwr_n_d;
  logic        ce0_n_q, ce0_n_d;
  logic        cas0_n_q, cas0_n_d;
  logic        cas2_n_q, cas2_n_d;
  logic        asel_n_q, asel_n_d;
  logic        time_n_q, time_n_d;

  logic [23:0] byte_addr;
  logic        is_time;
  logic        is_ext;

  // region decode of the incoming request address
  always_comb begin
    byte_addr = {bus.REQ_A, 1'b0};
    is_time   = (bus.REQ_A[23:8] == 16'hA130);
    is_ext    = (byte_addr >= 24'h400000) && (byte_addr <= 24'h9FFFFF) && !is_time;
  end

  // next-state and registered-output computation for the bus cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    be_d      = be_q;
    ext_d     = ext_q;
    va_d      = va_q;
    vdo_d     = vdo_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    bus_err_d = 1'b0;
    as_n_d    = as_n_q;
    lwr_n_d   = lwr_n_q;
    uwr_n_d   = uwr_n_q;
    ce0_n_d   = ce0_n_q;
    cas0_n_d  = cas0_n_q;
    cas2_n_d  = cas2_n_q;
    asel_n_d  = asel_n_q;
    time_n_d  = time_n_q;

    case (state_q)
      S_IDLE: begin
        if (bus.REQ) begin
          state_d  = S_ADDR;
          cnt_d    = 8'd0;
          we_d     = bus.REQ_WE;
          be_d     = bus.REQ_BE;
          ext_d    = is_ext;
          va_d     = bus.REQ_A;
          vdo_d    = bus.REQ_D;
          as_n_d   = 1'b0;
          ce0_n_d  = (bus.REQ_A[23:22] != 2'b00);
          asel_n_d = bus.REQ_A[23];
          time_n_d = !is_time;
        end
      end

      S_ADDR: begin
        state_d = S_STRB;
        cnt_d   = 8'd0;
        if (we_q) begin
          // a write with no byte enables still runs, just without byte strobes
          lwr_n_d  = !be_q[0];
          uwr_n_d  = !be_q[1];
          cas2_n_d = 1'b0;
        end else begin
          cas0_n_d = 1'b0;
        end
      end

      S_STRB: begin
        cnt_d = cnt_q + 8'd1;
        if ((!ext_q && (cnt_q == WAIT_LAST)) || (ext_q && !bus.DTACK_N)) begin
          state_d = S_RCVR;
          ack_d   = 1'b1;
          if (!we_q) rdata_d = bus.VDI;
        end else if (ext_q && (cnt_q == TMO_LAST)) begin
          // nobody answered: complete anyway so the host never hangs
          state_d   = S_RCVR;
          ack_d     = 1'b1;
          bus_err_d = 1'b1;
          rdata_d   = 16'hFFFF;
        end
        if (state_d == S_RCVR) begin
          as_n_d   = 1'b1;
          lwr_n_d  = 1'b1;
          uwr_n_d  = 1'b1;
          ce0_n_d  = 1'b1;
          cas0_n_d = 1'b1;
          cas2_n_d = 1'b1;
          asel_n_d = 1'b1;
          time_n_d = 1'b1;
        end
      end

      // recovery: strobes already high; no acceptance here so strobes get a real gap
      S_RCVR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      we_q      <= 1'b0;
      be_q      <= 2'b00;
      ext_q     <= 1'b0;
      va_q      <= '0;
      vdo_q     <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      bus_err_q <= 1'b0;
      as_n_q    <= 1'b1;
      lwr_n_q   <= 1'b1;
      uwr_n_q   <= 1'b1;
      ce0_n_q   <= 1'b1;
      cas0_n_q  <= 1'b1;
      cas2_n_q  <= 1'b1;
      asel_n_q  <= 1'b1;
      time_n_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      be_q      <= be_d;
      ext_q     <= ext_d;
      va_q      <= va_d;
      vdo_q     <= vdo_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      bus_err_q <= bus_err_d;
      as_n_q    <= as_n_d;
      lwr_n_q   <= lwr_n_d;
      uwr_n_q   <= uwr_n_d;
      ce0_n_q   <= ce0_n_d;
      cas0_n_q  <= cas0_n_d;
      cas2_n_q  <= cas2_n_d;
      asel_n_q  <= asel_n_d;
      time_n_q  <= time_n_d;
    end
  end

  assign bus.ACK     = ack_q;
  assign bus.REQ_Q   = rdata_q;
  assign bus.BUS_ERR = bus_err_q;
  assign bus.VA      = va_q;
  assign bus.VDO     = vdo_q;
  assign bus.AS_N    = as_n_q;
  assign bus.LWR_N   = lwr_n_q;
  assign bus.UWR_N   = uwr_n_q;
  assign bus.CE0_N   = ce0_n_q;
  assign bus.CAS0_N  = cas0_n_q;
  assign bus.CAS2_N  = cas2_n_q;
  assign bus.ASEL_N  = asel_n_q;
  assign bus.TIME_N  = time_n_q;

endmodule

// File: tb/tb_cart_bus_master.sv
// tb/tb_cart_bus_master.sv - scoreboard bench for cart_bus_master
module tb_cart_bus_master;
  localparam int WAIT_CYC = 2;
  localparam int TIMEOUT  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  cart_bus_master_if bus ();

  cart_bus_master #(.WAIT_CYC(WAIT_CYC), .TIMEOUT(TIMEOUT)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [16:0] sb_q[$];
  logic [15:0] last_q = 16'h0;
  int  hi_run = 0;
  bit  seen_low = 0;
  int  gap_checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // pop expected completion on every ACK and track write-strobe recovery gaps
  always @(negedge clk) begin
    if (rst) begin
      seen_low = 0;
      hi_run   = 0;
    end else begin
      if (bus.ACK) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_ack", 1, 0);
        end else begin
          logic [16:0] e;
          e = sb_q.pop_front();
          check("req_q", {16'h0, bus.REQ_Q}, {16'h0, e[15:0]});
          check("bus_err", {31'h0, bus.BUS_ERR}, {31'h0, e[16]});
        end
      end
      if (bus.LWR_N == 1'b0) begin
        if (seen_low && hi_run > 0) begin
          gap_checks++;
          check("lwr_gap", {31'h0, hi_run >= 2}, 1);
        end
        seen_low = 1;
        hi_run   = 0;
      end else begin
        hi_run++;
      end
    end
  end

  task automatic check_idle_strobes(input string tag);
    check({tag, "_strb"}, {24'h0, bus.AS_N, bus.LWR_N, bus.UWR_N, bus.CE0_N,
                           bus.CAS0_N, bus.CAS2_N, bus.ASEL_N, bus.TIME_N}, 32'hFF);
  endtask

  // one request; b2b marks a request raised while the previous ACK is showing
  task automatic do_req(input logic [23:0] addr, input bit we, input logic [1:0] be,
                        input logic [15:0] d, input logic [15:0] vdi, input int dtack_t,
                        input bit keep, input bit b2b);
    bit tmo, ext, ce0, asel, tim, got;
    int exp_t, t;
    logic [15:0] exp_q;
    tim  = (addr[23:8] == 16'hA130);
    ce0  = (addr < 24'h400000);
    asel = (addr < 24'h800000);
    ext  = (addr >= 24'h400000) && (addr <= 24'h9FFFFF) && !tim;
    tmo  = ext && (dtack_t < 0);
    if (!ext)     exp_t = 2 + WAIT_CYC;
    else if (tmo) exp_t = 3 + TIMEOUT;
    else          exp_t = dtack_t + 1;
    if (tmo)      exp_q = 16'hFFFF;
    else if (!we) exp_q = vdi;
    else          exp_q = last_q;
    last_q = exp_q;
    sb_q.push_back({tmo, exp_q});
    bus.REQ = 1'b1; bus.REQ_A = addr[23:1]; bus.REQ_WE = we; bus.REQ_BE = be;
    bus.REQ_D = d; bus.VDI = vdi; bus.DTACK_N = 1'b1;
    t = b2b ? -1 : 0;
    got = 0;
    while (!got && t < 400) begin
      @(negedge clk);
      t++;
      if (t == 1) begin
        check("addr_as_n", {31'h0, bus.AS_N}, 0);
        check("addr_ce0_n", {31'h0, bus.CE0_N}, {31'h0, !ce0});
        check("addr_asel_n", {31'h0, bus.ASEL_N}, {31'h0, !asel});
        check("addr_time_n", {31'h0, bus.TIME_N}, {31'h0, !tim});
        check("addr_va", {9'h0, bus.VA}, {9'h0, addr[23:1]});
        check("addr_strb_hi", {30'h0, bus.LWR_N, bus.CAS0_N}, 32'h3);
        if (we) check("addr_vdo", {16'h0, bus.VDO}, {16'h0, d});
      end
      if (t >= 2 && t < exp_t) begin
        check("strb_cas0_n", {31'h0, bus.CAS0_N}, {31'h0, we});
        check("strb_cas2_n", {31'h0, bus.CAS2_N}, {31'h0, !we});
        check("strb_lwr_n", {31'h0, bus.LWR_N}, {31'h0, !(we && be[0])});
        check("strb_uwr_n", {31'h0, bus.UWR_N}, {31'h0, !(we && be[1])});
      end
      if (bus.ACK) begin
        got = 1;
        check("ack_latency", t, exp_t);
        check_idle_strobes("rcvr");
        bus.DTACK_N = 1'b1;
        if (!keep) bus.REQ = 1'b0;
      end else if (t == dtack_t) begin
        bus.DTACK_N = 1'b0;
      end
    end
    if (!got) check("ack_wait", 0, 1);
  endtask

  initial begin
    bus.REQ = 0; bus.REQ_A = '0; bus.REQ_WE = 0; bus.REQ_BE = 2'b00;
    bus.REQ_D = '0; bus.VDI = '0; bus.DTACK_N = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_strobes("reset");
    check("reset_ack", {31'h0, bus.ACK}, 0);
    check("reset_err", {31'h0, bus.BUS_ERR}, 0);
    check("reset_q", {16'h0, bus.REQ_Q}, 0);
    check("reset_va", {9'h0, bus.VA}, 0);
    check("reset_vdo", {16'h0, bus.VDO}, 0);
    rst = 1'b0;
    @(negedge clk);

    do_req(24'h000200, 0, 2'b00, 16'h0000, 16'h1234, -1, 0, 0);
    @(negedge clk);
    do_req(24'hA13000, 1, 2'b01, 16'h0003, 16'h0000, -1, 0, 0);
    check("va_hold", {9'h0, bus.VA}, 32'h509800);
    @(negedge clk);
    check("va_hold_idle", {9'h0, bus.VA}, 32'h509800);
    check("vdo_hold_idle", {16'h0, bus.VDO}, 32'h0003);
    do_req(24'h000100, 1, 2'b01, 16'h00AA, 16'h0000, -1, 1, 0);
    do_req(24'h000102, 1, 2'b01, 16'h00BB, 16'h0000, -1, 0, 1);
    @(negedge clk);
    do_req(24'h100000, 1, 2'b00, 16'h5555, 16'h0000, -1, 0, 0);
    @(negedge clk);
    do_req(24'h100010, 1, 2'b10, 16'hAA00, 16'h0000, -1, 0, 0);
    @(negedge clk);
    do_req(24'h840000, 0, 2'b11, 16'h0000, 16'hBEEF, 6, 0, 0);
    @(negedge clk);
    do_req(24'h500000, 0, 2'b11, 16'h0000, 16'h1111, -1, 0, 0);
    @(negedge clk);
    do_req(24'hC00000, 0, 2'b11, 16'h0000, 16'h5A5A, -1, 0, 0);
    @(negedge clk);

    // reset in the middle of a strobe phase
    bus.REQ = 1'b1; bus.REQ_A = 23'h000300; bus.REQ_WE = 0; bus.VDI = 16'h7777;
    repeat (3) @(negedge clk);
    check("pre_rst_cas0_n", {31'h0, bus.CAS0_N}, 0);
    rst = 1'b1;
    @(negedge clk);
    check_idle_strobes("mid_rst");
    check("mid_rst_ack", {31'h0, bus.ACK}, 0);
    rst = 1'b0;
    bus.REQ = 1'b0;
    last_q = 16'h0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_ack", {31'h0, bus.ACK}, 0);
    end
    do_req(24'h000400, 0, 2'b00, 16'h0000, 16'hC0DE, -1, 0, 0);
    repeat (3) @(negedge clk);

    check("sb_empty", sb_q.size(), 0);
    check("gap_seen", {31'h0, gap_checks > 0}, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
